// File: rtl/freq_ratio_meter_if.sv
// freq_ratio_meter_if
//   Groups the measurement-side signals of freq_ratio_meter into one bundle.
//   Ports / signals:
//     enable     - measurement enable (driven by master)
//     sig_in     - measured signal, asynchronous to clk (driven by master)
//     period     - clk cycles between the last two detected rising edges
//     high_time  - clk cycles sig_in was high within that period
//     valid      - one-cycle pulse when period/high_time update
//     locked     - enough consecutive equal periods have been seen
//     timeout    - no rising edge within 2^CNT_W-1 cycles
//   Modports:
//     master - stimulus side (drives enable/sig_in, reads results)
//     slave  - meter side (reads enable/sig_in, drives results)
interface freq_ratio_meter_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  modport master (
    output enable, sig_in,
    input  period, high_time, valid, locked, timeout
  );

  modport slave (
    input  enable, sig_in,
    output period, high_time, valid, locked, timeout
  );
endinterface

// File: rtl/freq_ratio_meter.sv
// freq_ratio_meter
//   Measures a slow clock-derived signal against clk: reports its period and
//   high time in clk cycles, flags lock once the period has repeated
//   LOCK_COUNT times in a row, and flags a timeout when edges stop arriving.
//   Parameters:
//     CNT_W      - width of the period/high-time counters and outputs
//     LOCK_COUNT - consecutive matching periods needed for lock (1..255)
//   Ports:
//     clk - system clock, rising edge
//     rst - asynchronous active-high reset
//     bus - freq_ratio_meter_if slave modport (enable, sig_in in;
//           period, high_time, valid, locked, timeout out)
module freq_ratio_meter #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4
) (
  input logic               clk,
  input logic               rst,
  freq_ratio_meter_if.slave bus
);

  localparam int              MATCH_W     = 8;
  localparam logic [MATCH_W-1:0] LOCK_TARGET = MATCH_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t             state, state_next;
  logic               s1, s2, sd;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
  logic [CNT_W-1:0]   hi_lat, hi_lat_next;
  logic [CNT_W-1:0]   period_q, period_next;
  logic [CNT_W-1:0]   high_q, high_next;
  logic [MATCH_W-1:0] match_cnt, match_next;
  logic               first, first_next;
  logic               valid_q, valid_next;
  logic               locked_q, locked_next;
  logic               timeout_q, timeout_next;

  // Two-flop synchroniser plus a history flop; every edge decision below
  // uses only the synchronised rise/fall strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      sd <= s2;
    end
  end

  assign rise    = s2 & ~sd;
  assign fall    = ~s2 & sd;
  assign cnt_inc = cnt + CNT_W'(1);

  // State and measurement registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      match_cnt <= '0;
      first     <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      hi_lat    <= hi_lat_next;
      period_q  <= period_next;
      high_q    <= high_next;
      match_cnt <= match_next;
      first     <= first_next;
      valid_q   <= valid_next;
      locked_q  <= locked_next;
      timeout_q <= timeout_next;
    end
  end

  // Next-state and datapath decisions. Disabling wins over everything and
  // only clears lock; the last measurement and timeout flag are kept so
  // software can still read them. A rise landing on the saturated count is
  // recorded as a normal period (the count wraps to 0 in the period field)
  // rather than as a timeout.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_lat_next  = hi_lat;
    period_next  = period_q;
    high_next    = high_q;
    match_next   = match_cnt;
    first_next   = first;
    valid_next   = 1'b0;
    locked_next  = locked_q;
    timeout_next = timeout_q;

    if (!bus.enable) begin
      state_next  = IDLE;
      cnt_next    = '0;
      locked_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next = '0;
          if (rise) begin
            state_next   = MEASURE;
            match_next   = '0;
            first_next   = 1'b1;
            timeout_next = 1'b0;
          end
        end
        MEASURE: begin
          cnt_next = cnt_inc;
          if (fall) begin
            hi_lat_next = cnt_inc;
          end
          if (rise) begin
            period_next = cnt_inc;
            high_next   = hi_lat;
            valid_next  = 1'b1;
            cnt_next    = '0;
            // The first period after IDLE has nothing to compare against.
            if (first) begin
              first_next = 1'b0;
              match_next = '0;
            end else if (cnt_inc == period_q) begin
              if (match_cnt < LOCK_TARGET) begin
                match_next = match_cnt + MATCH_W'(1);
              end
            end else begin
              match_next = '0;
            end
            // Lock follows the updated match count so a mismatch drops it
            // on the same edge that publishes the new period.
            locked_next = (match_next == LOCK_TARGET);
          end else if (cnt == CNT_MAX) begin
            timeout_next = 1'b1;
            locked_next  = 1'b0;
            state_next   = IDLE;
            cnt_next     = '0;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.locked    = locked_q;
  assign bus.timeout   = timeout_q;

endmodule
